// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: data width, channel count, pooling phase
// encoding and the signed max / ReLU helpers used by every pooling lane.
package cnn_pkg;

   localparam int DW     = 12;
   localparam int NUM_CH = 3;

   // What an accepted pixel does to a lane, decoded from the column/row parity.
   typedef enum logic [1:0] {
      PH_HOLD  = 2'd0,
      PH_STORE = 2'd1,
      PH_EMIT  = 2'd2
   } phase_t;

   function automatic logic signed [DW-1:0] max_s(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic signed [DW-1:0] relu(input logic signed [DW-1:0] x);
      return x[DW-1] ? '0 : x;
   endfunction

endpackage

// File: rtl/pool_lane.sv
// One channel of ReLU + 2x2 max-pooling: horizontal pair hold register,
// half-row line buffer of pair maxima, and the pooled output register.
// Build option: RELU_EN applies ReLU to incoming pixels; otherwise pure signed max.
module pool_lane
   import cnn_pkg::*;
#(
   parameter int IN_W = 8,
   parameter int DW   = cnn_pkg::DW,
   parameter int IW   = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 accept,
   input  phase_t               phase,
   input  logic [IW-1:0]        col_idx,
   input  logic signed [DW-1:0] din,
   output logic signed [DW-1:0] pool_out
);

   logic signed [DW-1:0] act;
   logic signed [DW-1:0] hold;
   logic signed [DW-1:0] pair_max;
   logic signed [DW-1:0] lbuf [IN_W/2];

`ifdef RELU_EN
   assign act = relu(din);
`else
   assign act = din;
`endif

   assign pair_max = max_s(hold, act);

   // Even column latches the left pixel; the odd row's odd column closes the window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold     <= '0;
         pool_out <= '0;
      end else if (accept) begin
         case (phase)
            PH_HOLD: hold     <= act;
            PH_EMIT: pool_out <= max_s(lbuf[col_idx], pair_max);
            default: ;
         endcase
      end
   end

   // Line buffer needs no reset: every entry is rewritten on an even row before it is read.
   always_ff @(posedge clk) begin
      if (accept && phase == PH_STORE)
         lbuf[col_idx] <= pair_max;
   end

endmodule

// File: rtl/conv2_relu_pool.sv
// ReLU + 2x2/stride-2 max-pool over the 3-channel conv2 raster stream.
// Build option: RELU_EN (ReLU in every lane); undefined gives a pure signed max-pool.
module conv2_relu_pool
   import cnn_pkg::*;
#(
   parameter int IN_W = 8,
   parameter int IN_H = 8,
   parameter int DW   = cnn_pkg::DW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid_in,
   input  logic signed [DW-1:0] conv_out_1,
   input  logic signed [DW-1:0] conv_out_2,
   input  logic signed [DW-1:0] conv_out_3,
   output logic signed [DW-1:0] pool_out_1,
   output logic signed [DW-1:0] pool_out_2,
   output logic signed [DW-1:0] pool_out_3,
   output logic                 valid_out
);

   localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam int RW = (IN_H > 1) ? $clog2(IN_H) : 1;
   localparam int IW = (IN_W > 2) ? $clog2(IN_W / 2) : 1;

   logic [CW-1:0]        col_cnt;
   logic [RW-1:0]        row_cnt;
   phase_t               phase;
   logic [IW-1:0]        col_idx;
   logic signed [DW-1:0] lane_in  [NUM_CH];
   logic signed [DW-1:0] lane_out [NUM_CH];

   always_comb begin
      phase   = PH_HOLD;
      if (col_cnt[0])
         phase = row_cnt[0] ? PH_EMIT : PH_STORE;
      col_idx = IW'(col_cnt >> 1);
   end

   // Raster position of the next pixel; wraps straight into the next frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_cnt   <= '0;
         row_cnt   <= '0;
         valid_out <= 1'b0;
      end else begin
         valid_out <= valid_in && (phase == PH_EMIT);
         if (valid_in) begin
            if (col_cnt == CW'(IN_W - 1)) begin
               col_cnt <= '0;
               row_cnt <= (row_cnt == RW'(IN_H - 1)) ? '0 : row_cnt + 1'b1;
            end else begin
               col_cnt <= col_cnt + 1'b1;
            end
         end
      end
   end

   assign lane_in[0] = conv_out_1;
   assign lane_in[1] = conv_out_2;
   assign lane_in[2] = conv_out_3;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      pool_lane #(
         .IN_W (IN_W),
         .DW   (DW),
         .IW   (IW)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .accept   (valid_in),
         .phase    (phase),
         .col_idx  (col_idx),
         .din      (lane_in[k]),
         .pool_out (lane_out[k])
      );
   end

   assign pool_out_1 = lane_out[0];
   assign pool_out_2 = lane_out[1];
   assign pool_out_3 = lane_out[2];

endmodule

// File: tb/tb_conv2_relu_pool.sv
// Directed, table-driven bench for conv2_relu_pool (8x8 map); expectations
// follow RELU_EN the same way the design does.
module tb_conv2_relu_pool;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              valid_in = 1'b0;
   logic signed [11:0] conv_out_1 = '0, conv_out_2 = '0, conv_out_3 = '0;
   logic signed [11:0] pool_out_1, pool_out_2, pool_out_3;
   logic              valid_out;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      int win_row;
      int win_col;
      int exp1;
      int raw2;
      int raw3;
   } vec_t;

   typedef struct {
      int p1;
      int p2;
      int p3;
   } out_t;

   vec_t tab [16];
   out_t out_q [$];

   conv2_relu_pool #(.IN_W(8), .IN_H(8), .DW(12)) dut (
      .clk        (clk),
      .rst        (rst),
      .valid_in   (valid_in),
      .conv_out_1 (conv_out_1),
      .conv_out_2 (conv_out_2),
      .conv_out_3 (conv_out_3),
      .pool_out_1 (pool_out_1),
      .pool_out_2 (pool_out_2),
      .pool_out_3 (pool_out_3),
      .valid_out  (valid_out)
   );

   always #5 clk = ~clk;

   function automatic int ref_act(input int x);
`ifdef RELU_EN
      return (x < 0) ? 0 : x;
`else
      return x;
`endif
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Mode 0: ramp / constant -5 / (col-row)*3, all shifted by off. Mode 1: mixed corner window.
   task automatic drivePixel(input int mode, input int r, input int c, input int off);
      int v1, v2, v3;
      if (mode == 0) begin
         v1 = r * 8 + c + off;
         v2 = -5 + off;
         v3 = (c - r) * 3 + off;
      end else begin
         v2 = 0;
         v3 = 0;
         if (r == 0 && c == 0)      v1 = -100;
         else if (r == 0 && c == 1) v1 = 7;
         else if (r == 1 && c == 0) v1 = 2047;
         else if (r == 1 && c == 1) v1 = -2048;
         else                       v1 = 0;
      end
      conv_out_1 = 12'(v1);
      conv_out_2 = 12'(v2);
      conv_out_3 = 12'(v3);
      valid_in   = 1'b1;
      @(posedge clk);
      #1;
      checkOutput($sformatf("valid_out after (%0d,%0d)", r, c), int'(valid_out),
                  ((r % 2 == 1) && (c % 2 == 1)) ? 1 : 0);
      if (valid_out)
         out_q.push_back('{int'(pool_out_1), int'(pool_out_2), int'(pool_out_3)});
      @(negedge clk);
   endtask

   task automatic idleCycle();
      valid_in = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("valid_out idle", int'(valid_out), 0);
      if (valid_out)
         out_q.push_back('{int'(pool_out_1), int'(pool_out_2), int'(pool_out_3)});
      @(negedge clk);
   endtask

   task automatic applyStimulus(input int mode, input int off, input int gapmax, input int npix);
      for (int i = 0; i < npix; i++) begin
         drivePixel(mode, i / 8, i % 8, off);
         if (gapmax > 0)
            repeat ($urandom_range(gapmax, 0)) idleCycle();
      end
   endtask

   task automatic compareFrame(input string tag, input int base, input int off);
      if (out_q.size() < base + 16) begin
         checkOutput({tag, " output count"}, out_q.size(), base + 16);
         return;
      end
      for (int i = 0; i < 16; i++) begin
         checkOutput($sformatf("%s ch1 win%0d", tag, i), out_q[base+i].p1, tab[i].exp1 + off);
         checkOutput($sformatf("%s ch2 win%0d", tag, i), out_q[base+i].p2, ref_act(tab[i].raw2 + off));
         checkOutput($sformatf("%s ch3 win%0d", tag, i), out_q[base+i].p3, ref_act(tab[i].raw3 + off));
      end
   endtask

   initial begin
      // Window (i,j): ch1 max = 16i+8+2j+1, ch3 raw max = (2j+1-2i)*3, ch2 = -5 everywhere.
      tab = '{
         '{0,0, 9,-5,  3}, '{0,1,11,-5,  9}, '{0,2,13,-5, 15}, '{0,3,15,-5, 21},
         '{1,0,25,-5, -3}, '{1,1,27,-5,  3}, '{1,2,29,-5,  9}, '{1,3,31,-5, 15},
         '{2,0,41,-5, -9}, '{2,1,43,-5, -3}, '{2,2,45,-5,  3}, '{2,3,47,-5,  9},
         '{3,0,57,-5,-15}, '{3,1,59,-5, -9}, '{3,2,61,-5, -3}, '{3,3,63,-5,  3}
      };

      repeat (3) @(negedge clk);
      checkOutput("reset valid_out", int'(valid_out), 0);
      checkOutput("reset pool_out_1", int'(pool_out_1), 0);
      checkOutput("reset pool_out_3", int'(pool_out_3), 0);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] ramp frame");
      out_q.delete();
      applyStimulus(0, 0, 0, 64);
      idleCycle();
      checkOutput("ramp pulse count", out_q.size(), 16);
      compareFrame("ramp", 0, 0);
      checkOutput("ramp hold after frame", int'(pool_out_1), 63);

      $display("[TB] reset mid-stream");
      out_q.delete();
      applyStimulus(0, 0, 0, 10);
      checkOutput("pre-reset valid_out", int'(valid_out), 1);
      rst = 1'b1;
      #1;
      checkOutput("async reset valid_out", int'(valid_out), 0);
      checkOutput("async reset pool_out_1", int'(pool_out_1), 0);
      checkOutput("async reset pool_out_2", int'(pool_out_2), 0);
      valid_in = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      out_q.delete();
      applyStimulus(0, 0, 0, 64);
      idleCycle();
      checkOutput("post-reset pulse count", out_q.size(), 16);
      compareFrame("post-reset", 0, 0);

      $display("[TB] mixed window");
      out_q.delete();
      applyStimulus(1, 0, 0, 64);
      idleCycle();
      checkOutput("mixed pulse count", out_q.size(), 16);
      if (out_q.size() > 0)
         checkOutput("mixed first ch1", out_q[0].p1, 2047);

      $display("[TB] random gaps");
      out_q.delete();
      applyStimulus(0, 0, 3, 64);
      repeat (3) idleCycle();
      checkOutput("gap pulse count", out_q.size(), 16);
      compareFrame("gap", 0, 0);

      $display("[TB] back-to-back frames");
      out_q.delete();
      applyStimulus(0, 0, 0, 64);
      applyStimulus(0, 1, 0, 64);
      repeat (2) idleCycle();
      checkOutput("b2b pulse count", out_q.size(), 32);
      compareFrame("b2b f1", 0, 0);
      compareFrame("b2b f2", 16, 1);

      $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
